// File: rtl/eq_band_scheduler.sv
// eq_band_scheduler: sequences the shared band filter engine per sample, gain-weights and accumulates band results, emits the saturated sum.
// Optional EQ_SAT_COUNT_EN adds a saturating count of clipped results (sat_count).
module eq_band_scheduler #(
  parameter int NUM_BANDS = 10,
  parameter int GAIN_W    = 13,
  parameter int FRAC      = 10,
  parameter int ACC_W     = 42
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [23:0]                 audio_in,
  input  logic                        audio_valid,
  output logic                        audio_ready,
  input  logic [NUM_BANDS*GAIN_W-1:0] gains_flat,
  input  logic                        gain_we,
  output logic                        band_start,
  output logic [3:0]                  band_sel,
  output logic [23:0]                 band_x,
  input  logic                        band_done,
  input  logic [23:0]                 band_y,
  output logic [23:0]                 audio_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        overrun_clr
`ifdef EQ_SAT_COUNT_EN
  , output logic [15:0]               sat_count
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  state_t state_q, state_d;
  logic [3:0] k_q, k_d, band_sel_q, band_sel_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sh_d;
  logic [NUM_BANDS*GAIN_W-1:0] shadow_q, shadow_d;
  logic pending_q, pending_d, overrun_q, overrun_d, clip_d;
  logic band_start_q, out_valid_q, audio_ready_q;
  logic [23:0] band_x_q, band_x_d, audio_out_q, audio_out_d, sat_d;
  logic signed [GAIN_W+24:0] prod;
  logic last;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    acc_d = acc_q;
    shadow_d = shadow_q;
    band_x_d = band_x_q;
    pending_d = pending_q | gain_we;
    prod = $signed(band_y) * $signed({1'b0, shadow_q[k_q*GAIN_W +: GAIN_W]});
    last = k_q == 4'(NUM_BANDS - 1);
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          shadow_d = gains_flat;
          pending_d = gain_we;
        end
        if (audio_valid) begin
          band_x_d = audio_in;
          acc_d = '0;
          k_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: if (band_done) begin
        acc_d = acc_q + ACC_W'(prod);
        state_d = last ? FINISH : ISSUE;
        k_d = last ? k_q : k_q + 4'd1;
      end
      FINISH: state_d = IDLE;
    endcase
    band_sel_d = state_d == ISSUE ? k_d : band_sel_q;
    overrun_d = overrun_clr ? 1'b0 : overrun_q | (audio_valid && state_q != IDLE);
    sh_d = acc_d >>> FRAC;
    clip_d = (sh_d[ACC_W-1:23] != '0) && (sh_d[ACC_W-1:23] != '1);
    sat_d = clip_d ? {sh_d[ACC_W-1], {23{~sh_d[ACC_W-1]}}} : sh_d[23:0];
    audio_out_d = state_d == FINISH ? sat_d : audio_out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      acc_q <= '0;
      shadow_q <= {NUM_BANDS{GAIN_W'(1 << FRAC)}};
      pending_q <= 1'b0;
      band_x_q <= '0;
      band_sel_q <= '0;
      band_start_q <= 1'b0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
      audio_ready_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      acc_q <= acc_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      band_x_q <= band_x_d;
      band_sel_q <= band_sel_d;
      band_start_q <= state_d == ISSUE;
      audio_out_q <= audio_out_d;
      out_valid_q <= state_d == FINISH;
      audio_ready_q <= state_d == IDLE;
      overrun_q <= overrun_d;
    end
  end
`ifdef EQ_SAT_COUNT_EN
  // clip_q holds the clip flag of the result presented during FINISH
  logic clip_q;
  logic [15:0] sat_count_q, sat_count_d;
  always_comb sat_count_d = overrun_clr ? 16'd0 :
    (state_q == FINISH && clip_q && sat_count_q != 16'hFFFF) ? sat_count_q + 16'd1 : sat_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= 1'b0;
      sat_count_q <= '0;
    end else begin
      clip_q <= clip_d;
      sat_count_q <= sat_count_d;
    end
  end
  assign sat_count = sat_count_q;
`endif
  assign audio_ready = audio_ready_q;
  assign busy = ~audio_ready_q;
  assign band_start = band_start_q;
  assign band_sel = band_sel_q;
  assign band_x = band_x_q;
  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_eq_band_scheduler.sv
// tb_eq_band_scheduler: scoreboard bench with a behavioural filter engine and directed samples.
module tb_eq_band_scheduler;
  localparam int NB = 10;
  localparam int GW = 13;
  logic clk = 0;
  logic rst = 1;
  logic [23:0] audio_in = '0;
  logic audio_valid = 0;
  logic audio_ready;
  logic [NB*GW-1:0] gains_flat = {NB{13'd1024}};
  logic gain_we = 0;
  logic band_start;
  logic [3:0] band_sel;
  logic [23:0] band_x;
  logic band_done = 0;
  logic [23:0] band_y = '0;
  logic [23:0] audio_out;
  logic out_valid, busy, overrun;
  logic overrun_clr = 0;
`ifdef EQ_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  eq_band_scheduler dut (
    .clk(clk), .rst(rst), .audio_in(audio_in), .audio_valid(audio_valid),
    .audio_ready(audio_ready), .gains_flat(gains_flat), .gain_we(gain_we),
    .band_start(band_start), .band_sel(band_sel), .band_x(band_x),
    .band_done(band_done), .band_y(band_y), .audio_out(audio_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef EQ_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int val; int c0; int lat;} exp_t;
  exp_t sb[$];
  int seq[$];
  int eng_delay = 1;
  int eng_mode = 0;
  int fixed_y = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] resp(int x);
    if (eng_mode == 0) return 24'(x / 10);
    if (eng_mode == 1) return 24'(x);
    return 24'(fixed_y);
  endfunction

  // behavioural engine: answers each band_start after eng_delay cycles
  initial forever begin
    @(posedge clk); #1;
    band_done = 0;
    if (band_start) begin
      int x;
      seq.push_back(int'(band_sel));
      x = int'($signed(band_x));
      repeat (eng_delay) @(posedge clk);
      #1;
      band_done = 1;
      band_y = resp(x);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        int bad;
        e = sb.pop_front();
        chk("audio_out", int'($signed(audio_out)), e.val);
        chk("latency", cyc - e.c0, e.lat);
        bad = (seq.size() == NB) ? 0 : 1;
        for (int i = 0; i < seq.size() && i < NB; i++) if (seq[i] != i) bad++;
        chk("band_sel_seq", bad, 0);
        seq.delete();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(int x, int ev, bit push);
    exp_t e;
    int n;
    n = 0;
    while (!audio_ready && n < 500) begin tick(); n++; end
    if (!audio_ready) begin chk("ready_timeout", 0, 1); return; end
    audio_in = 24'(x);
    audio_valid = 1;
    e.val = ev;
    e.c0 = cyc;
    e.lat = 1 + (eng_delay + 1) * NB;
    if (push) sb.push_back(e);
    tick();
    audio_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!audio_ready && n < 500) begin tick(); n++; end
    chk("idle_timeout", int'(audio_ready), 1);
  endtask

  task automatic wait_band(int k);
    int n;
    n = 0;
    while (!(band_start && band_sel == 4'(k)) && n < 500) begin tick(); n++; end
    chk("band_wait_timeout", int'(band_start && band_sel == 4'(k)), 1);
  endtask

  task automatic set_gains(int g);
    gains_flat = {NB{GW'(g)}};
    gain_we = 1;
    tick();
    gain_we = 0;
  endtask

  task automatic chk_sat(int v);
`ifdef EQ_SAT_COUNT_EN
    chk("sat_count", int'(sat_count), v);
`endif
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_audio_ready"}, int'(audio_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_band_start"}, int'(band_start), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_audio_out"}, int'(audio_out), 0);
    chk({tag, "_band_x"}, int'(band_x), 0);
    chk({tag, "_band_sel"}, int'(band_sel), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk_sat(0);
  endtask

  initial begin
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 0;
    tick();
    // unity gains, engine returns x/10
    eng_mode = 0;
    send(1000, 1000, 1); wait_idle();
    // all gains 17, echo engine; gain load coincides with accept
    eng_mode = 1;
    set_gains(17);
    send(24'h100000, 174080, 1); wait_idle();
    send(-3, -1, 1); wait_idle();
    // saturation both directions
    eng_mode = 2;
    fixed_y = 24'h7FFFFF;
    set_gains(8191);
    chk_sat(0);
    send(5, 8388607, 1); wait_idle();
    chk_sat(1);
    fixed_y = -8388608;
    send(5, -8388608, 1); wait_idle();
    chk_sat(2);
    // gain write during band 4 applies only to the next sample
    eng_mode = 1;
    send(-100, -8000, 1); wait_idle();
    send(100, 7999, 1);
    wait_band(4);
    tick();
    set_gains(1024);
    wait_idle();
    send(100, 1000, 1); wait_idle();
    // overrun: dropped sample, sticky flag, clear priority
    send(5, 50, 1);
    audio_in = 24'd77; audio_valid = 1;
    tick();
    audio_valid = 0;
    chk("overrun_set", int'(overrun), 1);
    chk("busy_running", int'(busy), 1);
    wait_idle();
    chk("overrun_sticky", int'(overrun), 1);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("overrun_cleared", int'(overrun), 0);
    chk_sat(0);
    send(6, 60, 1);
    audio_valid = 1; overrun_clr = 1;
    tick();
    audio_valid = 0; overrun_clr = 0;
    chk("overrun_clr_priority", int'(overrun), 0);
    wait_idle();
    // slow engine
    eng_delay = 5;
    send(7, 70, 1); wait_idle();
    // reset during band 3 wait; pending gains discarded
    send(1000, 0, 0);
    set_gains(17);
    wait_band(3);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk_idle_outputs("midreset");
    seq.delete();
    repeat (10) tick();
    eng_delay = 1;
    eng_mode = 0;
    send(1000, 1000, 1); wait_idle();
    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
